// File: rtl/wb_p2p_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_p2p_master_pkg
// Shared constants for sequencers that drive wb_p2p_master towards an
// i2c_master_top-style 8-bit register file with a 3-bit address space.
// These belong to the caller side; the master itself is protocol-agnostic
// and does not depend on them.
// ---------------------------------------------------------------------------
package wb_p2p_master_pkg;

  // Slave register map
  localparam logic [2:0] ADDR_PRER_LO = 3'd0;
  localparam logic [2:0] ADDR_PRER_HI = 3'd1;
  localparam logic [2:0] ADDR_CTR     = 3'd2;
  localparam logic [2:0] ADDR_TXR_RXR = 3'd3;
  localparam logic [2:0] ADDR_CR_SR   = 3'd4;

  // Command register bytes
  localparam logic [7:0] CMD_START_WRITE = 8'h90;
  localparam logic [7:0] CMD_WRITE       = 8'h10;
  localparam logic [7:0] CMD_WRITE_STOP  = 8'h50;
  localparam logic [7:0] CMD_READ_NACK   = 8'h28;  // stop bit deliberately clear

  // Control register: core enable
  localparam logic [7:0] CTR_ENABLE = 8'h80;

endpackage

// File: rtl/wb_p2p_master.sv
// ---------------------------------------------------------------------------
// wb_p2p_master
// Single-transaction point-to-point Wishbone classic master. A one-cycle
// read or write request from a local sequencer starts one bus cycle; the
// slave's ack ends it and produces a one-cycle completion pulse.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   o_wbs_adr/dat/we      Wishbone address, write data, write enable
//   o_wbs_stb/cyc         Wishbone strobe and cycle (always equal here)
//   i_wbs_dat, i_wbs_ack  Wishbone read data and acknowledge
//   i_ren, i_wren         read / write request (sampled only when idle)
//   i_addr, i_data        address / write data latched with the request
//   o_data                last read data, held until the next read ends
//   o_data_val            one-cycle pulse: read completed
//   o_done                one-cycle pulse: any transaction completed
// ---------------------------------------------------------------------------
module wb_p2p_master (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [2:0] o_wbs_adr,
  output logic [7:0] o_wbs_dat,
  input  logic [7:0] i_wbs_dat,
  output logic       o_wbs_we,
  output logic       o_wbs_stb,
  input  logic       i_wbs_ack,
  output logic       o_wbs_cyc,
  input  logic       i_ren,
  input  logic       i_wren,
  input  logic [7:0] i_data,
  input  logic [2:0] i_addr,
  output logic [7:0] o_data,
  output logic       o_data_val,
  output logic       o_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic       we_q, we_d;
  logic       cyc_q, cyc_d;
  logic [7:0] rdata_q, rdata_d;
  logic       data_val_q, data_val_d;
  logic       done_q, done_d;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    rdata_d    = rdata_q;
    data_val_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Ack while idle is ignored; write wins if both requests are high.
        if (i_wren || i_ren) begin
          adr_d   = i_addr;
          dat_d   = i_data;
          we_d    = i_wren;
          cyc_d   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Requests are ignored here so a poller may keep i_ren asserted.
        if (i_wbs_ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (!we_q) begin
            rdata_d    = i_wbs_dat;
            data_val_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      rdata_q    <= '0;
      data_val_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      rdata_q    <= rdata_d;
      data_val_q <= data_val_d;
      done_q     <= done_d;
    end
  end

  assign o_wbs_adr  = adr_q;
  assign o_wbs_dat  = dat_q;
  assign o_wbs_we   = we_q;
  // Point-to-point link: strobe is never deasserted within a cycle.
  assign o_wbs_stb  = cyc_q;
  assign o_wbs_cyc  = cyc_q;
  assign o_data     = rdata_q;
  assign o_data_val = data_val_q;
  assign o_done     = done_q;

  // Bus protocol checks
  a_stb_needs_cyc: assert property (@(posedge i_clk) o_wbs_stb |-> o_wbs_cyc);

  a_busy_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (state_q == ST_BUSY && !i_wbs_ack) |=>
      ($stable(o_wbs_adr) && $stable(o_wbs_dat) && $stable(o_wbs_we) && o_wbs_cyc));

endmodule

// File: tb/tb_wb_p2p_master.sv
module tb_wb_p2p_master;
  import wb_p2p_master_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [2:0] o_wbs_adr;
  logic [7:0] o_wbs_dat;
  logic [7:0] i_wbs_dat;
  logic       o_wbs_we;
  logic       o_wbs_stb;
  logic       i_wbs_ack;
  logic       o_wbs_cyc;
  logic       i_ren = 1'b0;
  logic       i_wren = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [2:0] i_addr = 3'd0;
  logic [7:0] o_data;
  logic       o_data_val;
  logic       o_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_read;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  // Slave model: acks after slave_delay idle cycles of stb, one-cycle ack.
  int         slave_delay = 1;
  logic [7:0] slave_rdata = 8'h00;
  logic       slave_ack = 1'b0;
  logic       idle_ack = 1'b0;
  logic [7:0] slave_dat = 8'h00;
  int         slave_cnt = 0;

  assign i_wbs_ack = slave_ack | idle_ack;
  assign i_wbs_dat = slave_dat;

  always #5 i_clk = ~i_clk;

  wb_p2p_master dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_wbs_adr  (o_wbs_adr),
    .o_wbs_dat  (o_wbs_dat),
    .i_wbs_dat  (i_wbs_dat),
    .o_wbs_we   (o_wbs_we),
    .o_wbs_stb  (o_wbs_stb),
    .i_wbs_ack  (i_wbs_ack),
    .o_wbs_cyc  (o_wbs_cyc),
    .i_ren      (i_ren),
    .i_wren     (i_wren),
    .i_data     (i_data),
    .i_addr     (i_addr),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .o_done     (o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_reset) begin
      slave_ack = 1'b0;
      slave_cnt = 0;
    end else if (slave_ack) begin
      slave_ack = 1'b0;
    end else if (o_wbs_cyc && o_wbs_stb) begin
      if (slave_cnt >= slave_delay) begin
        slave_ack = 1'b1;
        slave_dat = slave_rdata;
        slave_cnt = 0;
      end else begin
        slave_cnt++;
      end
    end
  end

  // Completion monitor: pops one expectation per done pulse.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_done) begin
        check("mon.expected_done", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("mon.data_val", o_data_val, e.is_read);
          if (e.is_read) check("mon.o_data", o_data, e.data);
          $display("txn done: %s o_data=%02h", e.is_read ? "read " : "write", o_data);
        end
      end else begin
        check("mon.val_without_done", o_data_val, 0);
      end
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [2:0] a, input logic [7:0] d,
                     input int dly, input logic [7:0] rdat, input bit toggle, input string tag);
    int busy;
    bit seen;
    busy = 0;
    seen = 0;
    slave_delay = dly;
    slave_rdata = rdat;
    @(negedge i_clk);
    i_ren = rd; i_wren = wr; i_addr = a; i_data = d;
    sb.push_back('{is_read: !wr, data: rdat});
    @(negedge i_clk);
    i_ren = 1'b0; i_wren = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      if (o_done) begin
        seen = 1;
      end else begin
        check({tag, ".cyc"}, o_wbs_cyc, 1);
        check({tag, ".stb"}, o_wbs_stb, 1);
        check({tag, ".adr"}, o_wbs_adr, a);
        check({tag, ".dat"}, o_wbs_dat, d);
        check({tag, ".we"}, o_wbs_we, wr);
        busy++;
        if (toggle) begin
          i_ren = c[0]; i_wren = ~c[0]; i_addr = ~a; i_data = ~d;
        end
        @(negedge i_clk);
      end
    end
    i_ren = 1'b0; i_wren = 1'b0; i_addr = a; i_data = d;
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".bus_cycles"}, busy, dly + 1);
    check({tag, ".cyc_at_done"}, o_wbs_cyc, 0);
    check({tag, ".we_at_done"}, o_wbs_we, 0);
    @(negedge i_clk);
    check({tag, ".done_one_cycle"}, o_done, 0);
    check({tag, ".no_new_cycle"}, o_wbs_cyc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst.cyc", o_wbs_cyc, 0);
    check("rst.stb", o_wbs_stb, 0);
    check("rst.we", o_wbs_we, 0);
    check("rst.adr", o_wbs_adr, 0);
    check("rst.dat", o_wbs_dat, 0);
    check("rst.o_data", o_data, 0);
    check("rst.done", o_done, 0);
    check("rst.val", o_data_val, 0);
    i_reset = 1'b0;

    // Write, registered-ack slave
    txn(0, 1, ADDR_PRER_LO, 8'h0F, 1, 8'h33, 0, "wr");
    check("wr.o_data_unchanged", o_data, 8'h00);
    check("wr.adr_held", o_wbs_adr, ADDR_PRER_LO);
    check("wr.dat_held", o_wbs_dat, 8'h0F);

    // Read of 0xA5 from CR/SR
    txn(1, 0, ADDR_CR_SR, 8'h00, 1, 8'hA5, 0, "rd");
    repeat (3) @(negedge i_clk);
    check("rd.o_data_hold", o_data, 8'hA5);

    // Slow slave, requests toggled while busy
    txn(0, 1, ADDR_TXR_RXR, CMD_START_WRITE, 5, 8'h11, 1, "slow_wr");
    txn(1, 0, ADDR_CR_SR, 8'h00, 4, 8'h5C, 1, "slow_rd");

    // Simultaneous read and write request: write wins
    txn(1, 1, ADDR_CTR, CTR_ENABLE, 1, 8'h77, 0, "both");
    check("both.o_data_unchanged", o_data, 8'h5C);

    // Polling with i_ren held high: back-to-back reads
    slave_delay = 1;
    slave_rdata = 8'h02;
    @(negedge i_clk);
    i_ren = 1'b1; i_addr = ADDR_CR_SR;
    sb.push_back('{is_read: 1'b1, data: 8'h02});
    sb.push_back('{is_read: 1'b1, data: 8'h00});
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_done && n < 20);
    check("poll.first_latency", n, 3);
    slave_rdata = 8'h00;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_done && n < 20);
    i_ren = 1'b0;
    check("poll.gap", n, 3);
    @(negedge i_clk);
    check("poll.no_third", o_wbs_cyc, 0);
    check("poll.o_data", o_data, 8'h00);

    // Ack while idle is ignored
    @(negedge i_clk);
    idle_ack = 1'b1;
    @(negedge i_clk);
    idle_ack = 1'b0;
    check("idle_ack.done", o_done, 0);
    check("idle_ack.cyc", o_wbs_cyc, 0);
    @(negedge i_clk);
    check("idle_ack.done2", o_done, 0);

    // Reset while busy
    slave_delay = 10;
    @(negedge i_clk);
    i_wren = 1'b1; i_addr = ADDR_PRER_HI; i_data = 8'h55;
    @(negedge i_clk);
    i_wren = 1'b0;
    check("rst_busy.cyc_before", o_wbs_cyc, 1);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("rst_busy.cyc", o_wbs_cyc, 0);
    check("rst_busy.stb", o_wbs_stb, 0);
    check("rst_busy.done", o_done, 0);
    check("rst_busy.adr", o_wbs_adr, 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_busy.done_after", o_done, 0);
    txn(0, 1, 3'd5, CMD_WRITE_STOP, 1, 8'h00, 0, "post_rst_wr");

    check("sb.empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_p2p_master.md
# wb_p2p_master

Single-transaction, point-to-point Wishbone classic master that turns one-cycle read/write request pulses from a local sequencer into Wishbone bus cycles. It sits between a polling state machine (for example the TCA9555 poller) and an 8-bit Wishbone slave with a 3-bit address space, such as the OpenCores-compatible `i2c_master_top` register file. It reports completion with single-cycle pulses and returns read data.

## Interface
Parameters: none.

Ports:
- `i_clk` in 1 — single clock; all logic on rising edge.
- `i_reset` in 1 — synchronous, active-high reset.
- `o_wbs_adr` out 3 — Wishbone address.
- `o_wbs_dat` out 8 — Wishbone write data.
- `i_wbs_dat` in 8 — Wishbone read data.
- `o_wbs_we` out 1 — Wishbone write enable.
- `o_wbs_stb` out 1 — Wishbone strobe.
- `i_wbs_ack` in 1 — Wishbone acknowledge.
- `o_wbs_cyc` out 1 — Wishbone cycle.
- `i_ren` in 1 — read request, sampled only when idle.
- `i_wren` in 1 — write request, sampled only when idle.
- `i_data` in 8 — write data, latched with the request.
- `i_addr` in 3 — register address, latched with the request.
- `o_data` out 8 — last read data, held until the next read completes.
- `o_data_val` out 1 — one-cycle pulse: read completed, `o_data` valid.
- `o_done` out 1 — one-cycle pulse: any transaction (read or write) completed.

## Operation
- Two states: IDLE and BUSY.
- IDLE, on `i_wren` or `i_ren`:
  - Latch `i_addr` into `o_wbs_adr`.
  - Latch `i_data` into `o_wbs_dat`.
  - Set `o_wbs_we = i_wren`; write wins if both requests are high.
  - Assert `o_wbs_cyc` and `o_wbs_stb`; go to BUSY.
- BUSY:
  - Hold all bus outputs stable.
  - `i_ren` and `i_wren` are ignored; callers may hold `i_ren` high while polling.
- BUSY, on `i_wbs_ack`:
  - Deassert `o_wbs_cyc`, `o_wbs_stb` and `o_wbs_we`.
  - Pulse `o_done`.
  - If the transaction was a read, capture `i_wbs_dat` into `o_data` and pulse `o_data_val` in the same cycle as `o_done`.
  - Return to IDLE.
- `o_wbs_adr` and `o_wbs_dat` keep their last values when idle.
- No timeout: BUSY persists until ack or reset.
- Reset values:
  - `o_wbs_cyc`, `o_wbs_stb`, `o_wbs_we`, `o_done`, `o_data_val` = 0.
  - `o_wbs_adr` = 0, `o_wbs_dat` = 0, `o_data` = 0.
  - State = IDLE.
- Reset mid-transaction drops `cyc` and `stb` on the next edge; no done or valid pulse is produced.

## Timing
- All outputs are registered.
- Request sampled high at edge E0 → `cyc`/`stb` high after E0.
- `ack` sampled at edge En → `cyc`/`stb`/`we` low after En, and `o_done` (plus `o_data_val` for reads) high for exactly the cycle after En.
- With a slave that acks one cycle after `stb` (registered ack, as in `i2c_master_top`): `done` appears 2 edges after the request edge, and the bus cycle spans 2 clocks.
- Back-to-back operation: a request present while `o_done` is high is accepted at that cycle's closing edge, since the master is already IDLE.
- `ack` while IDLE is ignored.
- `ack` must be a single-cycle pulse per Wishbone classic; a held `ack` only completes the one outstanding transaction.

## Structure
- Single flat module; no sub-modules.
- Shared package (owned by the caller side, not used inside this block):
  - Slave register addresses: PRER_LO=0, PRER_HI=1, CTR=2, TXR/RXR=3, CR/SR=4.
  - CR command bytes: 0x90 start+write, 0x10 write, 0x50 write+stop, 0x28 read+nack (stop bit not set).
  - CTR enable: 0x80.
- Expected size: about 120 lines, including a short bus-protocol assertion section (no `stb` without `cyc`; stable address/data while BUSY).

## Test plan
- Write, slave ack 1 cycle after `stb`: `i_wren` pulse with addr=0, data=0x0F → bus shows adr=0, dat=0x0F, we=1 for 2 cycles; `o_done` pulses once; `o_data_val` stays 0.
- Read, slave returns 0xA5 at addr 4 → we=0; `o_data` = 0xA5 with `o_done` and `o_data_val` pulsed in the same cycle; `o_data` holds 0xA5 afterwards.
- Slow slave, ack delayed 5 cycles; `i_ren`/`i_wren` toggled during BUSY → adr/dat/we unchanged; exactly one completion; no extra cycles started.
- Simultaneous `i_ren` and `i_wren` → write cycle (we=1) only.
- Polling: `i_ren` held high continuously (SR reads returning 0x02, then 0x00) → back-to-back read cycles, one `o_data_val` per ack, `o_data` tracks each value.
- Reset asserted while BUSY → `cyc`/`stb` 0 on the next cycle, no `done`; a fresh write afterwards completes normally.
